// File: rtl/fruit80_keystream_xor.sv
// fruit80_keystream_xor
//   Consumes the Fruit-80 serial keystream bit z. During the first
//   INIT_CYCLES clocks after reset release z is discarded (cipher
//   initialisation). Afterwards z is packed MSB-first into bytes, which are
//   buffered in a DEPTH-entry FIFO. Each plaintext byte is XORed with the
//   oldest buffered keystream byte and emitted as a registered ciphertext
//   byte. Encryption and decryption are the same operation.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   z         keystream bit, sampled every clock edge
//   pt_data   plaintext byte          pt_valid  plaintext valid
//   pt_ready  plaintext accepted this cycle (combinational)
//   ct_data   ciphertext byte (reg)   ct_valid  ciphertext valid (reg)
//   ct_ready  sink accepts ciphertext
//   ks_run    high once initialisation is over
//   ks_level  keystream bytes currently buffered
//   ks_ovf    sticky: a keystream byte was dropped on a full FIFO
//   byte_cnt  ciphertext bytes delivered, wraps at 16 bits
//   state_dbg current FSM state (0 = INIT, 1 = RUN)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. pt_ready never depends on pt_valid. Once ct_valid is
// raised, ct_data stays stable until the edge where ct_ready is seen high.
module fruit80_keystream_xor #(
  parameter int INIT_CYCLES = 160,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       z,
  input  logic [7:0]                 pt_data,
  input  logic                       pt_valid,
  output logic                       pt_ready,
  output logic [7:0]                 ct_data,
  output logic                       ct_valid,
  input  logic                       ct_ready,
  output logic                       ks_run,
  output logic [$clog2(DEPTH):0]     ks_level,
  output logic                       ks_ovf,
  output logic [15:0]                byte_cnt,
  output logic                       state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(INIT_CYCLES + 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   init_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      sr;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;

  logic            push_req, push, pop, fire, full;
  logic [7:0]      byte_in;

  // FSM next state: leave INIT on the last discard cycle.
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == CW'(INIT_CYCLES - 1))
      state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nxt;
  end

  assign state_dbg = state;

  // The byte completes with the current z as its LSB.
  assign byte_in  = {sr[6:0], z};
  assign push_req = (state == S_RUN) && (bit_cnt == 3'd7);
  assign full     = (level == LW'(DEPTH));
  assign pt_ready = (level != '0) && (!ct_valid || ct_ready);
  assign fire     = pt_valid && pt_ready;
  assign pop      = fire;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt <= '0;
      ks_run   <= 1'b0;
      bit_cnt  <= '0;
      sr       <= '0;
    end else begin
      if (state == S_INIT) init_cnt <= init_cnt + CW'(1);
      ks_run <= (state_nxt == S_RUN);
      if (state == S_RUN) begin
        sr      <= byte_in;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ks_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push_req && !push) ks_ovf <= 1'b1;
    end
  end

  assign ks_level = level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ct_data  <= '0;
      ct_valid <= 1'b0;
      byte_cnt <= '0;
    end else begin
      if (fire) begin
        ct_data  <= pt_data ^ mem[rd_ptr];
        ct_valid <= 1'b1;
      end else if (ct_ready) begin
        ct_valid <= 1'b0;
      end
      if (ct_valid && ct_ready) byte_cnt <= byte_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fruit80_keystream_xor.sv
// Testbench for fruit80_keystream_xor (INIT_CYCLES=4, DEPTH=4).
// Inputs change on the falling edge; the reference model advances on the
// rising edge and registered outputs are compared 1 ns later.
module tb_fruit80_keystream_xor;

  localparam int INIT  = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        z;
  logic [7:0]  pt_data;
  logic        pt_valid;
  logic        pt_ready;
  logic [7:0]  ct_data;
  logic        ct_valid;
  logic        ct_ready;
  logic        ks_run;
  logic [2:0]  ks_level;
  logic        ks_ovf;
  logic [15:0] byte_cnt;
  logic        state_dbg;

  fruit80_keystream_xor #(.INIT_CYCLES(INIT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .z(z),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ks_run(ks_run), .ks_level(ks_level), .ks_ovf(ks_ovf),
    .byte_cnt(byte_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since release, pending keystream bits, byte
  // queue, and the ciphertext scoreboard.
  int          m_cyc;
  logic        bitq[$];
  logic [7:0]  ks_q[$];
  logic [7:0]  exp_q[$];
  logic        m_ct_valid;
  logic [7:0]  m_ct_data;
  logic [15:0] m_cnt;
  logic        m_ovf;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_cyc = 0;
    bitq.delete();
    ks_q.delete();
    exp_q.delete();
    m_ct_valid = 1'b0;
    m_ct_data  = 8'h00;
    m_cnt      = 16'h0;
    m_ovf      = 1'b0;
  endtask

  // Called right after a falling edge with the inputs already driven.
  task automatic step();
    logic       m_pr, fire;
    logic [7:0] b;
    #1;
    m_pr = (ks_q.size() != 0) && (!m_ct_valid || ct_ready);
    check("pt_ready", 16'(pt_ready), 16'(m_pr));
    if (m_ct_valid && ct_ready && exp_q.size() != 0)
      check("ct_deliver", 16'(ct_data), 16'(exp_q[0]));
    @(posedge clk);
    fire = pt_valid && m_pr;
    if (m_ct_valid && ct_ready) begin
      m_cnt++;
      if (exp_q.size() != 0) exp_q.delete(0);
    end
    if (fire) begin
      m_ct_data  = pt_data ^ ks_q[0];
      ks_q.delete(0);
      m_ct_valid = 1'b1;
      exp_q.push_back(m_ct_data);
    end else if (ct_ready) begin
      m_ct_valid = 1'b0;
    end
    if (m_cyc >= INIT) begin
      bitq.push_back(z);
      if (bitq.size() == 8) begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], bitq[i]};
        bitq.delete();
        if (ks_q.size() < DEPTH) ks_q.push_back(b);
        else                     m_ovf = 1'b1;
      end
    end
    m_cyc++;
    #1;
    check("ct_valid", 16'(ct_valid), 16'(m_ct_valid));
    check("ct_data",  16'(ct_data),  16'(m_ct_data));
    check("ks_level", 16'(ks_level), 16'(ks_q.size()));
    check("ks_run",   16'(ks_run),   16'(m_cyc >= INIT));
    check("ks_ovf",   16'(ks_ovf),   16'(m_ovf));
    check("byte_cnt", byte_cnt,      m_cnt);
    @(negedge clk);
  endtask

  task automatic rstep();
    z = 1'($urandom_range(0, 1));
    step();
  endtask

  // Asserted away from any rising edge; outputs must clear with no clock.
  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    #1;
    check("rst_ct_data",  16'(ct_data),  16'h0);
    check("rst_ct_valid", 16'(ct_valid), 16'h0);
    check("rst_pt_ready", 16'(pt_ready), 16'h0);
    check("rst_ks_run",   16'(ks_run),   16'h0);
    check("rst_ks_level", 16'(ks_level), 16'h0);
    check("rst_ks_ovf",   16'(ks_ovf),   16'h0);
    check("rst_byte_cnt", byte_cnt,      16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    int         guard;
    rst = 1'b0; z = 1'b0; pt_valid = 1'b0; pt_data = 8'h00; ct_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Plaintext waits through INIT; z=1 during INIT must not leak in.
    pt_valid = 1'b1; pt_data = 8'hFF; ct_ready = 1'b1;
    repeat (INIT) begin z = 1'b1; step(); end
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) begin z = pat[i]; step(); end
    check("first_level", 16'(ks_level), 16'h1);
    rstep();
    check("encrypt_ct",    16'(ct_data),  16'h4D);
    check("encrypt_valid", 16'(ct_valid), 16'h1);
    check("encrypt_level", 16'(ks_level), 16'h0);
    pt_valid = 1'b0;
    rstep();
    check("encrypt_cnt", byte_cnt, 16'h1);

    // Backpressure with two bytes buffered.
    ct_ready = 1'b0;
    guard = 0;
    while (ks_q.size() < 2 && guard < 40) begin rstep(); guard++; end
    check("bp_two_bytes", 16'(ks_q.size() >= 2), 16'h1);
    pt_valid = 1'b1;
    repeat (5) begin pt_data = 8'($urandom); rstep(); end
    ct_ready = 1'b1;
    repeat (4) begin pt_data = 8'($urandom); rstep(); end

    // Overflow: no plaintext for more than five keystream bytes.
    pt_valid = 1'b0;
    repeat (48) rstep();
    check("ovf_level", 16'(ks_level), 16'h4);
    check("ovf_flag",  16'(ks_ovf),   16'h1);
    pt_valid = 1'b1;
    repeat (24) begin pt_data = 8'($urandom); rstep(); end

    // Random traffic.
    repeat (300) begin
      pt_valid = 1'($urandom_range(0, 1));
      ct_ready = ($urandom_range(0, 3) != 0);
      pt_data  = 8'($urandom);
      rstep();
    end

    // Reset with a ciphertext byte in flight.
    pt_valid = 1'b1; ct_ready = 1'b0;
    guard = 0;
    while (!m_ct_valid && guard < 40) begin rstep(); guard++; end
    check("pre_rst_valid", 16'(ct_valid), 16'h1);
    rstep();
    do_reset();

    // INIT repeats in full, then more random traffic.
    repeat (200) begin
      pt_valid = 1'($urandom_range(0, 1));
      ct_ready = ($urandom_range(0, 3) != 0);
      pt_data  = 8'($urandom);
      rstep();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
